fma_unit: RTL and testbench
===========================

Name: fma_unit

Overview:
- Per-thread Q1.15 fused multiply-add stage: computes rd_data + rs*rt with a single rounding step and saturation.
- Sits between the thread's register file read ports (rs, rt, rd_data) and the register file's FMA write-back input (fma_out).
- Multi-cycle. Starts in the core's EXECUTE state and drives a busy flag; the scheduler holds EXECUTE while busy. The result is stable before UPDATE.

Parameters:
- DATA_BITS, 16, operand and result width (Q1.15 format).
- FRAC_BITS, 15, number of fractional bits; the product is shifted right by this amount.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  thread active. When low, the FSM is forced to IDLE and fma_out holds its value.
- core_state  input  3  core state; 3'b101 = EXECUTE, 3'b110 = UPDATE.
- decoded_fma_enable  input  1  the current instruction is FMA.
- rs  input  DATA_BITS  multiplicand (Q1.15).
- rt  input  DATA_BITS  multiplier (Q1.15).
- rd_data  input  DATA_BITS  accumulator addend (Q1.15).
- fma_out  output  DATA_BITS  registered result.
- fma_busy  output  1  operation in flight; the scheduler stalls EXECUTE while this is high.
- fma_valid  output  1  fma_out holds the result of the current instruction.
- fma_overflow  output  1  the last result saturated. Sticky until the next start.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE.
  - fma_out = 0, fma_busy = 0, fma_valid = 0, fma_overflow = 0.
  - Internal operand and product registers cleared.
- FSM states: IDLE, MUL, ACC, DONE.
  - IDLE: start when enable && core_state == EXECUTE && decoded_fma_enable.
    - Capture rs, rt, rd_data.
    - Clear fma_overflow and fma_valid.
    - Go to MUL.
  - MUL:
    - Capture the signed 16x16 -> 32-bit product (Q2.30).
    - Go to ACC.
  - ACC:
    - Shift the product right arithmetically by FRAC_BITS into a 17-bit signed value (rounding per the optional feature).
    - Add rd_data sign-extended to 18 bits.
    - Saturate to [0x8000, 0x7FFF] and register the result into fma_out.
    - Set fma_overflow if saturation occurred.
    - Go to DONE.
  - DONE:
    - fma_valid = 1.
    - Stay while core_state == EXECUTE.
    - On any other core_state, go to IDLE. fma_valid drops to 0; fma_out and fma_overflow hold.
- fma_busy = 1 exactly in MUL and ACC (combinational decode of state).
- Latency:
  - Start edge E0 enters MUL.
  - E1 registers the product.
  - E2 writes fma_out and enters DONE.
  - fma_busy is high for 2 cycles. fma_valid is high from the cycle after E2.
- Operands are sampled only at start. Changes on rs, rt or rd_data during MUL/ACC have no effect.
- In IDLE, no start occurs if decoded_fma_enable is low or core_state != EXECUTE. Outputs hold.
- enable deasserted mid-operation: the FSM returns to IDLE on the next edge and the operation is abandoned. fma_out and fma_overflow keep their previous values; fma_valid = 0.
- Special case 0x8000 * 0x8000 (-1 * -1 = +1.0): not representable. Saturates to 0x7FFF with fma_overflow = 1.
- Back-to-back FMAs: a new start is accepted only from IDLE. At least one non-EXECUTE cycle (UPDATE) separates consecutive operations.

Optional Feature:
- Macro: FMA_ROUND_EN.
- Defined: round-half-up. Add 1 << (FRAC_BITS-1) to the 32-bit product before the arithmetic shift.
- Undefined: truncate toward negative infinity (plain arithmetic shift).
- Latency and saturation rules are identical in both builds.

Test Plan:
- Basic: rs=0x4000, rt=0x4000, rd_data=0x1000, start in EXECUTE -> fma_busy high for 2 cycles, then fma_valid=1, fma_out=0x3000, fma_overflow=0.
- Positive saturation: rs=0x7FFF, rt=0x7FFF, rd_data=0x7FFF -> fma_out=0x7FFF, fma_overflow=1. Same result for rs=0x8000, rt=0x8000, rd_data=0x0000.
- Negative saturation: rs=0x8000, rt=0x7FFF, rd_data=0x8000 -> fma_out=0x8000, fma_overflow=1.
- Rounding: rs=0x0001, rt=0x4000, rd_data=0 -> 0x0001 with FMA_ROUND_EN, 0x0000 without. rs=0xFFFF, rt=0x4000, rd_data=0 -> 0x0000 with FMA_ROUND_EN, 0xFFFF without.
- Abort paths:
  - Assert reset during ACC -> all outputs 0 immediately, FSM IDLE.
  - Drop enable during MUL -> IDLE next edge, fma_out unchanged, fma_valid=0.
- Handshake:
  - Hold core_state=EXECUTE for 6 cycles after DONE -> fma_valid stays 1, no restart.
  - Move to UPDATE -> IDLE, fma_valid=0, fma_out held.
  - decoded_fma_enable=0 in EXECUTE -> no start, fma_busy stays 0.

Source files
------------

// File: rtl/fma_unit.sv
// fma_unit: per-thread Q1.15 fused multiply-add, fma_out = sat(rd_data + rs*rt).
// Three-edge pipeline (IDLE -> MUL -> ACC -> DONE), one rounding step, saturating result.
// Optional build macro FMA_ROUND_EN: round-half-up instead of truncation toward -inf.
module fma_unit #(
    parameter int DATA_BITS = 16,
    parameter int FRAC_BITS = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_fma_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic [DATA_BITS-1:0] fma_out,
    output logic                 fma_busy,
    output logic                 fma_valid,
    output logic                 fma_overflow
);

    localparam int PW = 2 * DATA_BITS;
    localparam logic [2:0] CS_EXECUTE = 3'b101;
    localparam logic [DATA_BITS-1:0] SAT_POS = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic [DATA_BITS-1:0] SAT_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};
`ifdef FMA_ROUND_EN
    localparam logic signed [PW-1:0] RND_HALF = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ACC  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t                       r_state;
    logic signed [DATA_BITS-1:0]  r_rs;
    logic signed [DATA_BITS-1:0]  r_rt;
    logic signed [DATA_BITS-1:0]  r_rd;
    logic signed [PW-1:0]         r_prod;

    logic                         w_start;
    logic signed [PW-1:0]         w_prod;
    logic signed [PW-1:0]         w_prod_adj;
    logic signed [PW-1:0]         w_shifted;
    logic signed [PW-1:0]         w_rd_ext;
    logic signed [PW-1:0]         w_sum;
    logic [DATA_BITS-1:0]         w_sat;
    logic                         w_ovf;

    assign w_start = enable && (core_state == CS_EXECUTE) && decoded_fma_enable;

    // Datapath: product, optional rounding, Q1.15 realignment, accumulate and saturate.
    // The sum is kept at full product width; it never exceeds the 18-bit range, so the
    // result equals the 17-bit shift / 18-bit add formulation exactly.
    always_comb begin
        w_prod     = r_rs * r_rt;
`ifdef FMA_ROUND_EN
        w_prod_adj = r_prod + RND_HALF;
`else
        w_prod_adj = r_prod;
`endif
        w_shifted  = w_prod_adj >>> FRAC_BITS;
        w_rd_ext   = {{DATA_BITS{r_rd[DATA_BITS-1]}}, r_rd};
        w_sum      = w_shifted + w_rd_ext;
        // In range when every bit from the Q1.15 sign upward agrees.
        if ((&w_sum[PW-1:DATA_BITS-1]) || !(|w_sum[PW-1:DATA_BITS-1])) begin
            w_sat = w_sum[DATA_BITS-1:0];
            w_ovf = 1'b0;
        end else if (w_sum[PW-1]) begin
            w_sat = SAT_NEG;
            w_ovf = 1'b1;
        end else begin
            w_sat = SAT_POS;
            w_ovf = 1'b1;
        end
    end

    // Control FSM with operand/product capture and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_prod       <= '0;
            fma_out      <= '0;
            fma_busy     <= 1'b0;
            fma_valid    <= 1'b0;
            fma_overflow <= 1'b0;
        end else if (!enable) begin
            // Thread inactive: abandon any operation, keep the last result.
            r_state   <= ST_IDLE;
            fma_busy  <= 1'b0;
            fma_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_rs         <= rs;
                        r_rt         <= rt;
                        r_rd         <= rd_data;
                        fma_overflow <= 1'b0;
                        fma_valid    <= 1'b0;
                        fma_busy     <= 1'b1;
                        r_state      <= ST_MUL;
                    end else begin
                        fma_busy <= 1'b0;
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod;
                    fma_busy <= 1'b1;
                    r_state  <= ST_ACC;
                end
                ST_ACC: begin
                    fma_out      <= w_sat;
                    fma_overflow <= w_ovf;
                    fma_valid    <= 1'b1;
                    fma_busy     <= 1'b0;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    fma_busy <= 1'b0;
                    if (core_state != CS_EXECUTE) begin
                        fma_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        fma_valid <= 1'b1;
                    end
                end
                default: begin
                    fma_busy  <= 1'b0;
                    fma_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fma_unit.sv
// Scoreboard bench for fma_unit: expected results are queued at issue time and a
// negedge monitor compares them when fma_valid rises. Handshake, abort and reset
// paths are checked directly by the stimulus process.
module tb_fma_unit;

    localparam logic [2:0] CS_EXEC = 3'b101;
    localparam logic [2:0] CS_UPD  = 3'b110;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  core_state;
    logic        decoded_fma_enable;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] rd_data;
    logic [15:0] fma_out;
    logic        fma_busy;
    logic        fma_valid;
    logic        fma_overflow;

    int checks;
    int errors;
    logic [16:0] sb_q[$];

    fma_unit #(.DATA_BITS(16), .FRAC_BITS(15)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .core_state         (core_state),
        .decoded_fma_enable (decoded_fma_enable),
        .rs                 (rs),
        .rt                 (rt),
        .rd_data            (rd_data),
        .fma_out            (fma_out),
        .fma_busy           (fma_busy),
        .fma_valid          (fma_valid),
        .fma_overflow       (fma_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare one expected result on each rising fma_valid.
    initial begin : monitor
        logic prev_valid;
        logic [16:0] exp_v;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (fma_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("sb_fma_out", {16'h0000, fma_out}, {16'h0000, exp_v[15:0]});
                    chk("sb_overflow", {31'd0, fma_overflow}, {31'd0, exp_v[16]});
                end
            end
            prev_valid = fma_valid;
        end
    end

    // Issue one FMA from IDLE (caller is #1 after a posedge) and walk it to UPDATE.
    task automatic run_fma(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] eo, input logic eov, input int hold);
        rs = a; rt = b; rd_data = c;
        core_state = CS_EXEC; decoded_fma_enable = 1'b1;
        sb_q.push_back({eov, eo});
        @(posedge clk); #1;
        chk("busy_mul", {31'd0, fma_busy}, 32'd1);
        chk("valid_mul", {31'd0, fma_valid}, 32'd0);
        // Operands must be ignored after the start edge.
        rs = 16'h1234; rt = 16'h5A5A; rd_data = 16'h7F00;
        @(posedge clk); #1;
        chk("busy_acc", {31'd0, fma_busy}, 32'd1);
        @(posedge clk); #1;
        chk("busy_done", {31'd0, fma_busy}, 32'd0);
        chk("valid_done", {31'd0, fma_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, fma_valid}, 32'd1);
            chk("hold_busy", {31'd0, fma_busy}, 32'd0);
        end
        core_state = CS_UPD; decoded_fma_enable = 1'b0;
        @(posedge clk); #1;
        chk("upd_valid", {31'd0, fma_valid}, 32'd0);
        chk("upd_out_held", {16'h0000, fma_out}, {16'h0000, eo});
        chk("upd_ovf_held", {31'd0, fma_overflow}, {31'd0, eov});
        core_state = 3'b000;
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [15:0] rnd_pos;
        logic [15:0] rnd_neg;
`ifdef FMA_ROUND_EN
        rnd_pos = 16'h0001;
        rnd_neg = 16'h0000;
`else
        rnd_pos = 16'h0000;
        rnd_neg = 16'hFFFF;
`endif
        checks = 0;
        errors = 0;
        reset = 1'b1; enable = 1'b1; core_state = 3'b000; decoded_fma_enable = 1'b0;
        rs = 16'h0000; rt = 16'h0000; rd_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {16'h0000, fma_out}, 32'd0);
        chk("rst_busy", {31'd0, fma_busy}, 32'd0);
        chk("rst_valid", {31'd0, fma_valid}, 32'd0);
        chk("rst_ovf", {31'd0, fma_overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_fma(16'h4000, 16'h4000, 16'h1000, 16'h3000, 1'b0, 0);
        run_fma(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 6);
        run_fma(16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 0);

        // Reset asserted while the operation is in ACC.
        rs = 16'h4000; rt = 16'h4000; rd_data = 16'h1000;
        core_state = CS_EXEC; decoded_fma_enable = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_acc_out", {16'h0000, fma_out}, 32'd0);
        chk("rst_acc_busy", {31'd0, fma_busy}, 32'd0);
        chk("rst_acc_valid", {31'd0, fma_valid}, 32'd0);
        chk("rst_acc_ovf", {31'd0, fma_overflow}, 32'd0);
        core_state = 3'b000; decoded_fma_enable = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, fma_busy}, 32'd0);

        run_fma(16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, 0);
        run_fma(16'hC000, 16'h4000, 16'h0000, 16'hE000, 1'b0, 0);
        run_fma(16'h0001, 16'h4000, 16'h0000, rnd_pos, 1'b0, 0);
        run_fma(16'hFFFF, 16'h4000, 16'h0000, rnd_neg, 1'b0, 0);
        run_fma(16'h4000, 16'h4000, 16'h1000, 16'h3000, 1'b0, 0);

        // Drop enable during MUL: abandoned, previous result kept.
        rs = 16'h7FFF; rt = 16'h7FFF; rd_data = 16'h7FFF;
        core_state = CS_EXEC; decoded_fma_enable = 1'b1;
        @(posedge clk); #1;
        chk("en_mul_busy", {31'd0, fma_busy}, 32'd1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("en_drop_busy", {31'd0, fma_busy}, 32'd0);
        chk("en_drop_valid", {31'd0, fma_valid}, 32'd0);
        chk("en_drop_out", {16'h0000, fma_out}, 32'h0000_3000);
        chk("en_drop_ovf", {31'd0, fma_overflow}, 32'd0);
        enable = 1'b1; core_state = 3'b000; decoded_fma_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("en_after_busy", {31'd0, fma_busy}, 32'd0);

        // No start without the FMA decode, or outside EXECUTE.
        core_state = CS_EXEC; decoded_fma_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("nodec_busy", {31'd0, fma_busy}, 32'd0);
        end
        core_state = CS_UPD; decoded_fma_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("noexec_busy", {31'd0, fma_busy}, 32'd0);
        end
        chk("idle_out_held", {16'h0000, fma_out}, 32'h0000_3000);
        core_state = 3'b000; decoded_fma_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
